hl_layer_sequencer: RTL and testbench



---
 rtl/hl_layer_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_hl_layer_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hl_layer_sequencer.sv
// hl_layer_sequencer: buffers one input vector, broadcasts it element by
// element to every neuron of a hidden layer, collects per-lane results and
// sticky overflow, and presents the layer output with a valid/ready handshake.
// A watchdog bounds the wait for neuron results.
module hl_layer_sequencer #(
    parameter int NUM_INPUTS     = 36,
    parameter int NUM_NEURONS    = 8,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [WIDTH-1:0]             IN_VALUE,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [WIDTH-1:0]             NEU_VALUE,
    output logic                         NEU_VALID,
    input  logic [NUM_NEURONS-1:0]       NEU_READY,
    input  logic [NUM_NEURONS*WIDTH-1:0] NEU_VALUE_OUT,
    input  logic [NUM_NEURONS-1:0]       NEU_VALID_OUT,
    input  logic [NUM_NEURONS-1:0]       NEU_OVERFLOW,
    output logic [NUM_NEURONS*WIDTH-1:0] OUT_VALUES,
    output logic [NUM_NEURONS-1:0]       OUT_OVERFLOW,
    output logic                         OUT_TIMEOUT,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("hl_layer_sequencer: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_RES,
        S_PRESENT
    } state_t;

    state_t                         state;
    logic [WIDTH-1:0]               in_buf [NUM_INPUTS];
    logic [IDX_W-1:0]               idx;
    logic [WD_W-1:0]                wd_cnt;
    logic [NUM_NEURONS-1:0]         done;
    logic [NUM_NEURONS-1:0]         done_next;
    logic                           accept;

    logic                           in_ready_q;
    logic [WIDTH-1:0]               neu_value_q;
    logic                           neu_valid_q;
    logic [NUM_NEURONS*WIDTH-1:0]   out_values_q;
    logic [NUM_NEURONS-1:0]         out_overflow_q;
    logic                           out_timeout_q;
    logic                           out_valid_q;

    assign IN_READY     = in_ready_q;
    assign NEU_VALUE    = neu_value_q;
    assign NEU_VALID    = neu_valid_q;
    assign OUT_VALUES   = out_values_q;
    assign OUT_OVERFLOW = out_overflow_q;
    assign OUT_TIMEOUT  = out_timeout_q;
    assign OUT_VALID    = out_valid_q;

    // in_ready_q is only high in IDLE/LOAD, so it fully qualifies an accept
    assign accept = IN_VALID & in_ready_q;

    // Lane-done mask including this cycle's strobes, used for same-cycle completion
    always_comb begin
        done_next = done | NEU_VALID_OUT;
    end

    // Input element buffer; pure data storage, no reset needed
    always_ff @(posedge CLK) begin
        if (RSTN && accept) begin
            in_buf[idx] <= IN_VALUE;
        end
    end

    // Sequencer FSM with all registered outputs
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state          <= S_IDLE;
            idx            <= '0;
            wd_cnt         <= '0;
            done           <= '0;
            in_ready_q     <= 1'b1;
            neu_value_q    <= '0;
            neu_valid_q    <= 1'b0;
            out_values_q   <= '0;
            out_overflow_q <= '0;
            out_timeout_q  <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            // broadcast strobe is a single-cycle pulse by default
            neu_valid_q <= 1'b0;

            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        if (state == S_IDLE) begin
                            // start of a new vector: drop all per-vector result state
                            done           <= '0;
                            out_overflow_q <= '0;
                            out_timeout_q  <= 1'b0;
                            out_values_q   <= '0;
                        end
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            in_ready_q <= 1'b0;
                            state      <= S_ISSUE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= S_LOAD;
                        end
                    end
                end

                S_ISSUE: begin
                    // neu_valid_q high means a pulse went out last cycle: enforce the gap
                    if ((&NEU_READY) && !neu_valid_q) begin
                        neu_value_q <= in_buf[idx];
                        neu_valid_q <= 1'b1;
                        if (idx == IDX_LAST) begin
                            idx    <= '0;
                            wd_cnt <= '0;
                            state  <= S_WAIT_RES;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end

                S_WAIT_RES: begin
                    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                        if (NEU_VALID_OUT[i]) begin
                            out_values_q[i*WIDTH +: WIDTH] <= NEU_VALUE_OUT[i*WIDTH +: WIDTH];
                        end
                    end
                    done           <= done_next;
                    out_overflow_q <= out_overflow_q | NEU_OVERFLOW;

                    // completion is tested first so it wins over a coincident timeout
                    if (&done_next) begin
                        out_valid_q   <= 1'b1;
                        out_timeout_q <= 1'b0;
                        state         <= S_PRESENT;
                    end else if (wd_cnt == WD_LAST) begin
                        out_valid_q   <= 1'b1;
                        out_timeout_q <= 1'b1;
                        state         <= S_PRESENT;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                S_PRESENT: begin
                    // results held stable; late strobes are ignored here
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hl_layer_sequencer.sv
// Testbench for hl_layer_sequencer: table of full vectors through a simple
// summing neuron model, plus hand-driven sequences for ready gating,
// staggered results, watchdog timeout, backpressure and mid-issue reset.
module tb_hl_layer_sequencer;

    localparam int NI = 4;
    localparam int NN = 3;
    localparam int W  = 8;
    localparam int TO = 16;

    logic              CLK = 1'b0;
    logic              RSTN;
    logic [W-1:0]      IN_VALUE;
    logic              IN_VALID;
    logic              IN_READY;
    logic [W-1:0]      NEU_VALUE;
    logic              NEU_VALID;
    logic [NN-1:0]     NEU_READY;
    logic [NN*W-1:0]   NEU_VALUE_OUT;
    logic [NN-1:0]     NEU_VALID_OUT;
    logic [NN-1:0]     NEU_OVERFLOW;
    logic [NN*W-1:0]   OUT_VALUES;
    logic [NN-1:0]     OUT_OVERFLOW;
    logic              OUT_TIMEOUT;
    logic              OUT_VALID;
    logic              OUT_READY;

    int checks = 0;
    int errors = 0;

    hl_layer_sequencer #(
        .NUM_INPUTS     (NI),
        .NUM_NEURONS    (NN),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .IN_VALUE      (IN_VALUE),
        .IN_VALID      (IN_VALID),
        .IN_READY      (IN_READY),
        .NEU_VALUE     (NEU_VALUE),
        .NEU_VALID     (NEU_VALID),
        .NEU_READY     (NEU_READY),
        .NEU_VALUE_OUT (NEU_VALUE_OUT),
        .NEU_VALID_OUT (NEU_VALID_OUT),
        .NEU_OVERFLOW  (NEU_OVERFLOW),
        .OUT_VALUES    (OUT_VALUES),
        .OUT_OVERFLOW  (OUT_OVERFLOW),
        .OUT_TIMEOUT   (OUT_TIMEOUT),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Neuron model: sums the broadcast elements, strobes the result a few cycles after the last one
    logic            auto_mode;
    logic [W-1:0]    lane_off;
    logic [NN-1:0]   man_vout;
    logic [NN-1:0]   man_ovf;
    logic [NN*W-1:0] man_val;
    logic [W-1:0]    m_acc;
    logic [W-1:0]    m_res;
    int              m_cnt;
    int              m_delay;
    logic            m_strobe;

    always @(posedge CLK) begin
        if (!RSTN) begin
            m_acc    <= '0;
            m_res    <= '0;
            m_cnt    <= 0;
            m_delay  <= 0;
            m_strobe <= 1'b0;
        end else begin
            m_strobe <= 1'b0;
            if (NEU_VALID) begin
                m_acc <= m_acc + NEU_VALUE;
                if (m_cnt == NI - 1) begin
                    m_cnt   <= 0;
                    m_delay <= 5;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (m_delay != 0) begin
                m_delay <= m_delay - 1;
                if (m_delay == 1) begin
                    m_strobe <= 1'b1;
                    m_res    <= m_acc;
                    m_acc    <= '0;
                end
            end
        end
    end

    // Lane i of the model returns sum + i*lane_off; manual mode lets the test drive lanes directly
    always_comb begin
        NEU_VALID_OUT = auto_mode ? {NN{m_strobe}} : man_vout;
        NEU_OVERFLOW  = auto_mode ? '0 : man_ovf;
        for (int i = 0; i < NN; i++) begin
            NEU_VALUE_OUT[i*W +: W] = auto_mode ? W'(m_res + W'(i) * lane_off) : man_val[i*W +: W];
        end
    end

    // Broadcast monitor: pulses never back-to-back and only issued when all lanes were ready
    logic           rdy_at_edge;
    logic           prev_nv = 1'b0;
    int             pulse_cnt = 0;
    logic [W-1:0]   pulse_vals[$];

    always @(posedge CLK) rdy_at_edge <= &NEU_READY;

    always @(negedge CLK) begin
        if (NEU_VALID) begin
            chk("pulse_spacing", 64'(prev_nv), 64'd0);
            chk("pulse_ready", 64'(rdy_at_edge), 64'd1);
            pulse_cnt++;
            pulse_vals.push_back(NEU_VALUE);
        end
        prev_nv = NEU_VALID;
    end

    task automatic send_vector(input logic [NI*W-1:0] v);
        for (int i = 0; i < NI; i++) begin
            chk("in_ready_load", 64'(IN_READY), 64'd1);
            IN_VALUE = v[i*W +: W];
            IN_VALID = 1'b1;
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        chk("in_ready_issue", 64'(IN_READY), 64'd0);
    endtask

    task automatic wait_pulses(input int k);
        int n = 0;
        int t = 0;
        while (n < k && t < 200) begin
            @(negedge CLK);
            t++;
            if (NEU_VALID) n++;
        end
        chk("wait_pulses", 64'(n), 64'(k));
    endtask

    task automatic wait_out(input int budget);
        int n = 0;
        while (!OUT_VALID && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("out_valid_wait", 64'(OUT_VALID), 64'd1);
    endtask

    task automatic complete_out();
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("out_valid_drop", 64'(OUT_VALID), 64'd0);
        chk("in_ready_return", 64'(IN_READY), 64'd1);
    endtask

    task automatic chk_pulses(input logic [NI*W-1:0] v);
        logic [W-1:0] e;
        chk("pulse_count", 64'(pulse_cnt), 64'(NI));
        for (int k = 0; k < NI; k++) begin
            e = v[k*W +: W];
            chk("pulse_value", 64'((k < pulse_vals.size()) ? pulse_vals[k] : 8'hxx), 64'(e));
        end
    endtask

    typedef struct {
        logic [NI*W-1:0] v;
        logic [W-1:0]    off;
        logic [NN*W-1:0] e;
    } vec_t;

    vec_t tbl[5];

    initial begin
        // element 0 is the least significant byte; lanes likewise
        tbl[0] = '{32'h04030201, 8'd0, 24'h0A0A0A};  // 1+2+3+4 = 10
        tbl[1] = '{32'h08070605, 8'd1, 24'h1C1B1A};  // 26, +1, +2
        tbl[2] = '{32'hFCFDFEFF, 8'd3, 24'hFCF9F6};  // -10 = F6, +3, +6
        tbl[3] = '{32'h0000017F, 8'd2, 24'h848280};  // 128 wraps to 80
        tbl[4] = '{32'h40302010, 8'd5, 24'hAAA5A0};  // A0, +5, +10

        RSTN      = 1'b0;
        IN_VALUE  = '0;
        IN_VALID  = 1'b0;
        NEU_READY = '1;
        OUT_READY = 1'b0;
        auto_mode = 1'b1;
        lane_off  = '0;
        man_vout  = '0;
        man_ovf   = '0;
        man_val   = '0;

        repeat (3) @(negedge CLK);
        chk("rst_in_ready", 64'(IN_READY), 64'd1);
        chk("rst_neu_value", 64'(NEU_VALUE), 64'd0);
        chk("rst_neu_valid", 64'(NEU_VALID), 64'd0);
        chk("rst_out_values", 64'(OUT_VALUES), 64'd0);
        chk("rst_out_overflow", 64'(OUT_OVERFLOW), 64'd0);
        chk("rst_out_timeout", 64'(OUT_TIMEOUT), 64'd0);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        RSTN = 1'b1;
        @(negedge CLK);

        // table of full vectors through the model
        for (int r = 0; r < 5; r++) begin
            lane_off  = tbl[r].off;
            pulse_cnt = 0;
            pulse_vals.delete();
            send_vector(tbl[r].v);
            wait_out(100);
            chk("vec_values", 64'(OUT_VALUES), 64'(tbl[r].e));
            chk("vec_overflow", 64'(OUT_OVERFLOW), 64'd0);
            chk("vec_timeout", 64'(OUT_TIMEOUT), 64'd0);
            chk_pulses(tbl[r].v);
            complete_out();
        end

        // ready gating: lane 1 not ready for 7 cycles after the 2nd pulse
        lane_off  = '0;
        pulse_cnt = 0;
        pulse_vals.delete();
        send_vector(32'h04030201);
        wait_pulses(2);
        NEU_READY[1] = 1'b0;
        repeat (7) @(negedge CLK);
        chk("gated_no_pulse", 64'(pulse_cnt), 64'd2);
        NEU_READY = '1;
        wait_out(100);
        chk("gated_values", 64'(OUT_VALUES), 64'h0A0A0A);
        chk_pulses(32'h04030201);
        complete_out();

        // staggered results; lane 0 strobes twice, the second value wins
        auto_mode = 1'b0;
        send_vector(32'h04030201);
        wait_pulses(4);
        for (int t = 1; t <= 10; t++) begin
            @(negedge CLK);
            man_vout = '0;
            man_ovf  = '0;
            if (t == 2) begin man_vout[0] = 1'b1; man_val[0*W +: W] = 8'h11; end
            if (t == 3) begin man_ovf[2] = 1'b1; end
            if (t == 4) begin man_vout[2] = 1'b1; man_val[2*W +: W] = 8'h33; end
            if (t == 5) begin man_vout[0] = 1'b1; man_val[0*W +: W] = 8'h21; end
            if (t == 9) begin man_vout[1] = 1'b1; man_val[1*W +: W] = 8'h22; end
            chk("stag_out_valid", 64'(OUT_VALID), 64'(t == 10));
        end
        man_vout = '0;
        chk("stag_values", 64'(OUT_VALUES), 64'h332221);
        chk("stag_overflow", 64'(OUT_OVERFLOW), 64'b100);
        chk("stag_timeout", 64'(OUT_TIMEOUT), 64'd0);
        complete_out();

        // watchdog: lane 0 never strobes
        send_vector(32'h08070605);
        wait_pulses(4);
        for (int t = 1; t <= TO; t++) begin
            @(negedge CLK);
            man_vout = '0;
            if (t == 3) begin
                man_vout = 3'b110;
                man_val  = 24'hA55A00;
            end
            chk("to_out_valid", 64'(OUT_VALID), 64'(t == TO));
        end
        man_vout = '0;
        chk("to_values", 64'(OUT_VALUES), 64'hA55A00);
        chk("to_timeout", 64'(OUT_TIMEOUT), 64'd1);
        chk("to_overflow", 64'(OUT_OVERFLOW), 64'd0);

        // backpressure while presenting; a strobe on lane 0 must be ignored
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            man_vout = '0;
            if (c == 2) begin
                man_vout = 3'b001;
                man_val  = 24'h000077;
            end
            chk("bp_out_valid", 64'(OUT_VALID), 64'd1);
            chk("bp_in_ready", 64'(IN_READY), 64'd0);
            chk("bp_values", 64'(OUT_VALUES), 64'hA55A00);
            chk("bp_timeout", 64'(OUT_TIMEOUT), 64'd1);
        end
        man_vout = '0;
        complete_out();

        // reset in the middle of broadcasting, then a clean vector
        auto_mode = 1'b1;
        lane_off  = '0;
        send_vector(32'h04030201);
        wait_pulses(2);
        RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        chk("mid_rst_in_ready", 64'(IN_READY), 64'd1);
        chk("mid_rst_neu_value", 64'(NEU_VALUE), 64'd0);
        chk("mid_rst_neu_valid", 64'(NEU_VALID), 64'd0);
        chk("mid_rst_out_values", 64'(OUT_VALUES), 64'd0);
        chk("mid_rst_out_overflow", 64'(OUT_OVERFLOW), 64'd0);
        chk("mid_rst_out_timeout", 64'(OUT_TIMEOUT), 64'd0);
        chk("mid_rst_out_valid", 64'(OUT_VALID), 64'd0);
        RSTN = 1'b1;
        @(negedge CLK);
        pulse_cnt = 0;
        pulse_vals.delete();
        send_vector(32'h08070605);
        wait_out(100);
        chk("post_rst_values", 64'(OUT_VALUES), 64'h1A1A1A);
        chk("post_rst_timeout", 64'(OUT_TIMEOUT), 64'd0);
        chk_pulses(32'h08070605);
        complete_out();

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1);
    end

endmodule
